sram_port_arbiter: RTL and testbench

- Shares one single-port synchronous `sram` instance (8-bit address, 16-bit data, 1-cycle read latency) between two requesters: the instruction-fetch port (F) and the execute-stage data port (D).
- Lets the CPU core run from a unified program/data memory instead of separate imem/dmem instances.
- Grants one access per cycle with priority to D, plus an anti-starvation counter for F.
- Returns read data with a one-cycle response pulse to the owning requester.

---
 rtl/sram_port_arbiter.sv | 115 +++++++++++
 tb/tb_sram_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter sharing one single-port synchronous SRAM.
// Data port wins conflicts; fetch is forced through after MAX_WAIT refusals.
module sram_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_cs,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       conflict_cnt
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_F    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0]        r_wait_cnt;
  logic [1:0]        r_owner;
  logic [15:0]       r_conflict;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_force_f;
  logic              w_grant_d;
  logic              w_grant_f;
  logic              w_both;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_din;
  logic [1:0]        w_owner_nxt;

  assign w_both    = f_req & d_req;
  assign w_force_f = (r_wait_cnt == WAIT_MAX);
  // Grants are masked during reset so every output reads 0 immediately.
  assign w_grant_d = ~rst & d_req & ~(f_req & w_force_f);
  assign w_grant_f = ~rst & f_req & ~w_grant_d;

  always_comb begin
    w_mem_addr  = r_mem_addr;
    w_mem_din   = r_mem_din;
    w_owner_nxt = OWN_NONE;
    unique case (1'b1)
      w_grant_d: begin
        w_mem_addr  = d_addr;
        w_mem_din   = d_wdata;
        w_owner_nxt = d_we ? OWN_NONE : OWN_D;
      end
      w_grant_f: begin
        w_mem_addr  = f_addr;
        w_owner_nxt = OWN_F;
      end
      default: ;
    endcase
  end

  assign f_ready      = w_grant_f;
  assign d_ready      = w_grant_d;
  assign mem_cs       = w_grant_f | w_grant_d;
  assign mem_we       = w_grant_d & d_we;
  assign mem_addr     = w_mem_addr;
  assign mem_din      = w_mem_din;
  assign conflict_cnt = r_conflict;

  assign f_rvalid = (r_owner == OWN_F);
  assign d_rvalid = (r_owner == OWN_D);
  // Response data passes straight through; the registers hold it afterwards.
  assign f_rdata  = f_rvalid ? mem_dout : r_f_rdata;
  assign d_rdata  = d_rvalid ? mem_dout : r_d_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_owner    <= OWN_NONE;
      r_conflict <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_f_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_mem_addr <= w_mem_addr;
      r_mem_din  <= w_mem_din;
      if (f_req && !w_grant_f)
        r_wait_cnt <= w_force_f ? WAIT_MAX : r_wait_cnt + 4'd1;
      else
        r_wait_cnt <= '0;
      if (w_both && r_conflict != 16'hFFFF)
        r_conflict <= r_conflict + 16'd1;
      if (f_rvalid)
        r_f_rdata <= mem_dout;
      if (d_rvalid)
        r_d_rdata <= mem_dout;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 256x16 SRAM.
// Expected values are hand-derived per cycle.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_ready;
  logic        f_rvalid;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        mem_cs;
  logic [15:0] mem_dout;
  logic [15:0] conflict_cnt;

  logic [15:0] sram [256];

  int vectors;
  int miscompares;

  sram_port_arbiter #(
    .ADDR_W(8), .DATA_W(16), .MAX_WAIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_cs(mem_cs), .mem_dout(mem_dout),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_din;
      else        mem_dout <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_d;
    logic exp_d;
    vectors     = 0;
    miscompares = 0;
    mem_dout    = 16'h0;
    for (int i = 0; i < 256; i++) sram[i] = 16'h1000 + 16'(i);
    rst = 1'b1;
    f_req = 0; f_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    #3;
    chk("rst_f_ready", f_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_rvalid", {f_rvalid, d_rvalid}, 0);
    chk("rst_mem_ctl", {mem_cs, mem_we}, 0);
    chk("rst_rdata", {f_rdata, d_rdata}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_conflict", conflict_cnt, 0);
    tick();
    rst = 1'b0;

    // F-only back-to-back reads of 0..3
    for (int k = 0; k < 5; k++) begin
      tick();
      f_req  = (k < 4);
      f_addr = 8'(k < 4 ? k : 0);
      #2;
      chk("f_only_ready", f_ready, (k < 4));
      chk("f_only_d_rdy", d_ready, 0);
      chk("f_only_rvalid", f_rvalid, (k > 0));
      if (k > 0) chk("f_only_rdata", f_rdata, 16'h1000 + 16'(k - 1));
      chk("f_only_d_rv", d_rvalid, 0);
      if (k < 4) chk("f_only_addr", mem_addr, k);
    end
    chk("idle_cs", mem_cs, 0);
    chk("idle_addr_hold", mem_addr, 3);
    tick();
    #2;
    chk("idle_f_rvalid", f_rvalid, 0);
    chk("idle_f_rdata_hold", f_rdata, 16'h1003);

    // D write 0x00A5 to 0x40, then read it back
    tick();
    d_req = 1; d_we = 1; d_addr = 8'h40; d_wdata = 16'h00A5;
    #2;
    chk("dw_ready", d_ready, 1);
    chk("dw_mem_we", mem_we, 1);
    chk("dw_mem_din", mem_din, 16'h00A5);
    chk("dw_mem_addr", mem_addr, 8'h40);
    tick();
    d_we = 0;
    #2;
    chk("dr_ready", d_ready, 1);
    chk("dr_mem_we", mem_we, 0);
    chk("dw_no_rvalid", d_rvalid, 0);
    tick();
    d_req = 0;
    #2;
    chk("dr_rvalid", d_rvalid, 1);
    chk("dr_rdata", d_rdata, 16'h00A5);
    chk("dr_f_rvalid", f_rvalid, 0);

    // Both reading continuously: D,D,D,F repeating
    prev_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      f_req = 1; f_addr = 8'h01;
      d_req = 1; d_we = 0; d_addr = 8'h02;
      #2;
      exp_d = ((k % 4) != 3);
      chk("both_d_ready", d_ready, exp_d);
      chk("both_f_ready", f_ready, !exp_d);
      chk("both_conflict", conflict_cnt, k);
      if (k > 0) begin
        chk("both_d_rvalid", d_rvalid, prev_d);
        chk("both_f_rvalid", f_rvalid, !prev_d);
        if (prev_d) chk("both_d_rdata", d_rdata, 16'h1002);
        else        chk("both_f_rdata", f_rdata, 16'h1001);
      end
      prev_d = exp_d;
    end
    tick();
    f_req = 0; d_req = 0;
    #2;
    chk("both_tail_f_rv", f_rvalid, 1);
    chk("both_tail_f_rd", f_rdata, 16'h1001);
    chk("both_tail_cnt", conflict_cnt, 8);

    // F read and D write of 0x10 together; D wins, F follows
    tick();
    f_req = 1; f_addr = 8'h10;
    d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 16'hBEEF;
    #2;
    chk("sim_d_ready", d_ready, 1);
    chk("sim_f_ready", f_ready, 0);
    chk("sim_mem_we", mem_we, 1);
    chk("sim_cnt", conflict_cnt, 8);
    tick();
    d_req = 0; d_we = 0;
    #2;
    chk("sim_f_ready2", f_ready, 1);
    chk("sim_mem_we2", mem_we, 0);
    chk("sim_d_rvalid", d_rvalid, 0);
    tick();
    f_req = 0;
    #2;
    chk("sim_f_rvalid", f_rvalid, 1);
    chk("sim_f_rdata", f_rdata, 16'hBEEF);
    chk("sim_cnt2", conflict_cnt, 9);
    chk("sim_mem_we3", mem_we, 0);

    // Reset one cycle after a D read grant
    tick();
    f_req = 1; f_addr = 8'h05;
    d_req = 1; d_we = 0; d_addr = 8'h40;
    #2;
    chk("pre_d_ready", d_ready, 1);
    tick();
    #2;
    chk("pre_d_ready2", d_ready, 1);
    chk("pre_d_rvalid", d_rvalid, 1);
    chk("pre_cnt", conflict_cnt, 10);
    tick();
    rst = 1;
    #2;
    chk("mid_rst_ready", {f_ready, d_ready}, 0);
    chk("mid_rst_rvalid", {f_rvalid, d_rvalid}, 0);
    chk("mid_rst_mem", {mem_cs, mem_we}, 0);
    chk("mid_rst_rdata", {f_rdata, d_rdata}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_cnt", conflict_cnt, 0);
    tick();
    rst = 0;
    #2;
    chk("post_d_rvalid", d_rvalid, 0);
    chk("post_cnt", conflict_cnt, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        #2;
      end
      chk("post_d_ready", d_ready, (k < 3));
      chk("post_f_ready", f_ready, (k == 3));
    end

    // Saturation of the conflict counter
    for (int k = 0; k < 65540; k++) @(posedge clk);
    #1;
    chk("sat_cnt", conflict_cnt, 16'hFFFF);
    tick();
    chk("sat_hold", conflict_cnt, 16'hFFFF);
    f_req = 0; d_req = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
